// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM peripheral.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W       = 8;
  localparam int unsigned PRESC_W         = 16;
  localparam int unsigned OUT_W           = 16;
  localparam int unsigned CLK_DIV_DEFAULT = 333;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  localparam pwm_cnt_t PWM_DUTY_FULL = 8'hFF;
  localparam pwm_cnt_t PWM_CNT_MAX   = 8'hFF;

  // Per-pin configuration as seen by the output stage.
  typedef struct packed {
    logic [OUT_W-1:0] en_out;
    logic [OUT_W-1:0] en_pwm;
  } pwm_cfg_t;

  // Full-scale duty is forced high so 0xFF never drops for the cnt==255 slot.
  function automatic logic pwm_level_f(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == PWM_DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter for the PWM peripheral.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   tick       : high while the prescaler sits at CLK_DIV-1
//   pwm_cnt    : period counter, advances on tick, wraps 255 -> 0
//   wrap       : high while tick is high and pwm_cnt == 255 (next edge wraps)
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     tick,
  output pwm_cnt_t pwm_cnt,
  output logic     wrap
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_nxt;
  pwm_cnt_t           cnt_nxt;
  logic               tick_nxt;
  logic               wrap_nxt;

  // tick and wrap are precomputed from next-state so they come out of flops.
  always_comb begin
    presc_nxt = presc_q + 1'b1;
    cnt_nxt   = pwm_cnt;
    if (presc_q == PRESC_MAX) begin
      presc_nxt = '0;
      cnt_nxt   = pwm_cnt + 1'b1;
    end
    tick_nxt = (presc_nxt == PRESC_MAX);
    wrap_nxt = tick_nxt && (cnt_nxt == PWM_CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pwm_cnt <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      presc_q <= presc_nxt;
      pwm_cnt <= cnt_nxt;
      tick    <= tick_nxt;
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM/static output peripheral with a shared duty cycle.
// Optional macro PWM_SHADOW_DUTY_EN: duty is latched only at period wrap,
// so a duty change takes effect at the next period start. Default build
// uses the duty input directly.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   en_reg_out_7_0/15_8     : per-pin output enable
//   en_reg_pwm_7_0/15_8     : per-pin PWM-mode select (else static high)
//   pwm_duty_cycle          : requested duty shared by all PWM pins
//   out                     : registered pin drive
//   period_start            : one-clk pulse after each period wrap
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
  output logic [OUT_W-1:0]     out,
  output logic                 period_start
);

  logic       tick;
  logic       wrap;
  pwm_cnt_t   pwm_cnt;
  pwm_cnt_t   duty_active;
  logic       pwm_level;
  logic       wrap_edge;
  pwm_cfg_t   cfg;
  logic [OUT_W-1:0] out_nxt;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .pwm_cnt (pwm_cnt),
    .wrap    (wrap)
  );

  // Edge on which pwm_cnt rolls 255 -> 0.
  assign wrap_edge = tick && wrap;

`ifdef PWM_SHADOW_DUTY_EN
  pwm_cnt_t duty_q;

  // Shadow duty: reload only at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (wrap_edge) begin
      duty_q <= pwm_duty_cycle;
    end
  end

  assign duty_active = duty_q;
`else
  assign duty_active = pwm_duty_cycle;
`endif

  assign pwm_level = pwm_level_f(pwm_cnt, duty_active);

  assign cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Per-pin mux: disabled -> 0, PWM mode -> level, static mode -> 1.
  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      if (cfg.en_out[i]) begin
        out_nxt[i] = cfg.en_pwm[i] ? pwm_level : 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_nxt;
      period_start <= wrap_edge;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral at CLK_DIV = 4.
module tb_pwm_peripheral;

  localparam int unsigned DIV = 4;
  localparam int          PER = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .CLK_DIV (DIV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until period_start is seen high; -1 if the budget runs out.
  task automatic wait_ps(input int limit, output int edges);
    edges = 0;
    while (edges < limit) begin
      step(1);
      edges++;
      if (period_start === 1'b1) return;
    end
    edges = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e, hi, bad, h1, h2;

    eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'h80;
    rst_n = 1'b0;
    step(3);
    check("rst_out", 32'(out), 32'h0);
    check("rst_ps", 32'(period_start), 32'h0);

    // Release away from the edge; first period_start after 256*DIV edges.
    rst_n = 1'b1;
    wait_ps(2 * PER, e);
    check("first_ps", 32'(e), 32'(PER));
    step(1);
    check("ps_single", 32'(period_start), 32'h0);

    // Static drive on pin 0.
    eo_lo = 8'h01; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00;
    step(1);
    check("static_1clk", 32'(out), 32'h0001);
    bad = 0;
    repeat (50) begin
      step(1);
      if (out !== 16'h0001) bad++;
    end
    check("static_held", 32'(bad), 32'h0);

    // 50% duty on low byte.
    eo_lo = 8'hFF; ep_lo = 8'hFF; duty = 8'h80;
    wait_ps(2 * PER, e);
    check("duty_ps", 32'(e > 0), 32'h1);
    hi = 0; bad = 0;
    for (int i = 0; i < PER; i++) begin
      step(1);
      if (out[7:0] === 8'hFF) hi++;
      if (out[15:8] !== 8'h00) bad++;
    end
    check("duty80_high", 32'(hi), 32'd512);
    check("duty80_upper", 32'(bad), 32'h0);

    // Duty 0x00 -> constant low over three periods.
    duty = 8'h00;
    wait_ps(2 * PER, e);
    check("duty00_ps", 32'(e > 0), 32'h1);
    bad = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      step(1);
      if (out !== 16'h0000) bad++;
    end
    check("duty00_low", 32'(bad), 32'h0);

    // Duty 0xFF -> constant high over three periods, including wraps.
    duty = 8'hFF;
    wait_ps(2 * PER, e);
    check("dutyFF_ps", 32'(e > 0), 32'h1);
    bad = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      step(1);
      if (out !== 16'h00FF) bad++;
    end
    check("dutyFF_high", 32'(bad), 32'h0);

    // Duty 0x40 -> 0xC0 once pwm_cnt reaches 100.
    duty = 8'h40;
    wait_ps(2 * PER, e);
    check("shadow_ps", 32'(e > 0), 32'h1);
    h1 = 0;
    for (int i = 1; i <= PER; i++) begin
      step(1);
      if (out[7:0] === 8'hFF) h1++;
`ifdef PWM_SHADOW_DUTY_EN
      if (i == 401) check("shadow_next_clk", 32'(out), 32'h0000);
`else
      if (i == 401) check("shadow_next_clk", 32'(out), 32'h00FF);
`endif
      if (i == 400) duty = 8'hC0;
    end
    h2 = 0;
    for (int i = 0; i < PER; i++) begin
      step(1);
      if (out[7:0] === 8'hFF) h2++;
    end
`ifdef PWM_SHADOW_DUTY_EN
    check("shadow_cur_high", 32'(h1), 32'd256);
`else
    check("shadow_cur_high", 32'(h1), 32'd624);
`endif
    check("shadow_next_high", 32'(h2), 32'd768);

    // Reset while pwm_cnt == 50, held 3 clks.
    wait_ps(2 * PER, e);
    check("midrst_ps", 32'(e > 0), 32'h1);
    step(200);
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_psl", 32'(period_start), 32'h0);
    step(3);
    check("midrst_held", 32'(out), 32'h0);
    rst_n = 1'b1;
    step(1);
`ifdef PWM_SHADOW_DUTY_EN
    check("midrst_first_out", 32'(out), 32'h0000);
`else
    check("midrst_first_out", 32'(out), 32'h00FF);
`endif
    wait_ps(2 * PER, e);
    check("midrst_restart", 32'(e), 32'(PER - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
